// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Helpers operate on MAX_REQ-wide vectors; callers cast to their own width.
package wrr_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int unsigned MAX_REQ = 32;

  // Binary index of the single set bit; 0 when no bit is set.
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

  // Thermometer code with bits 0..n set.
  function automatic logic [MAX_REQ-1:0] uint_to_thermo(input int unsigned n);
    logic [MAX_REQ-1:0] t;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      t[i] = (i <= n);
    end
    return t;
  endfunction

endpackage

// File: rtl/wrr_arbiter_pick.sv
// Combinational masked lowest-first pick; thermo marks the bits strictly above the winner.
module rr_pick #(
  parameter int unsigned nReq = 4
) (
  input  logic [nReq-1:0] request,
  input  logic [nReq-1:0] mask,
  output logic [nReq-1:0] winner,
  output logic [nReq-1:0] thermo
);
  import wrr_arbiter_pkg::*;

  logic [nReq-1:0] masked;
  logic [nReq-1:0] cand;

  always_comb begin
    masked = request & mask;
    cand   = (|masked) ? masked : request;
    winner = cand & (~cand + nReq'(1));
    thermo = '0;
    if (|cand) thermo = ~nReq'(uint_to_thermo(onehot_to_idx(MAX_REQ'(winner))));
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered grant and per-turn beat budget.
// Define WRR_ARBITER_LOCK_EN to hold a turn until the packet's last beat.
module wrr_arbiter #(
  parameter int unsigned nReq = 4,
  parameter int unsigned WW   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [nReq-1:0]            request,
  input  logic [nReq-1:0][WW-1:0]    weight,
  input  logic                       accept,
  input  logic                       last,
  output logic [nReq-1:0]            grant,
  output logic                       grant_valid,
  output logic [$clog2(nReq)-1:0]    grant_idx,
  output logic [WW-1:0]              credit_left
);
  import wrr_arbiter_pkg::*;

  localparam int unsigned IW = $clog2(nReq);

  arb_state_e      state, state_n;
  logic [nReq-1:0] mask, mask_n;
  logic [nReq-1:0] above, above_n;
  logic [nReq-1:0] grant_n;
  logic            grant_valid_n;
  logic [IW-1:0]   grant_idx_n;
  logic [WW-1:0]   credit_left_n;

  logic [nReq-1:0] pick_mask;
  logic [nReq-1:0] win_oh;
  logic [nReq-1:0] win_thermo;
  logic [IW-1:0]   win_idx;
  logic [WW-1:0]   win_credit;
  logic            rel;
  logic            do_load;
  logic            do_clear;

  // While busy, pick as if the rotation had already happened so a release regrants with no bubble.
  assign pick_mask = (state == ARB_BUSY) ? above : mask;

  rr_pick #(.nReq(nReq)) u_pick (
    .request (request),
    .mask    (pick_mask),
    .winner  (win_oh),
    .thermo  (win_thermo)
  );

  assign win_idx    = IW'(onehot_to_idx(MAX_REQ'(win_oh)));
  assign win_credit = (weight[win_idx] == '0) ? WW'(1) : weight[win_idx];

`ifdef WRR_ARBITER_LOCK_EN
  logic exhausted, exhausted_n;
  assign rel = (accept & last & (exhausted | (credit_left <= WW'(1)))) | ~request[grant_idx];
`else
  logic unused_last;
  assign unused_last = last;
  assign rel = (accept & (credit_left == WW'(1))) | ~request[grant_idx];
`endif

  always_comb begin
    state_n       = state;
    mask_n        = mask;
    above_n       = above;
    grant_n       = grant;
    grant_valid_n = grant_valid;
    grant_idx_n   = grant_idx;
    credit_left_n = credit_left;
`ifdef WRR_ARBITER_LOCK_EN
    exhausted_n   = exhausted;
`endif
    do_load       = 1'b0;
    do_clear      = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (|request) do_load = 1'b1;
      end
      ARB_BUSY: begin
        if (rel) begin
          mask_n = above;
          if (|request) do_load = 1'b1;
          else          do_clear = 1'b1;
        end else if (accept) begin
          credit_left_n = (credit_left == '0) ? '0 : credit_left - WW'(1);
`ifdef WRR_ARBITER_LOCK_EN
          if (credit_left <= WW'(1)) exhausted_n = 1'b1;
`endif
        end
      end
      default: do_clear = 1'b1;
    endcase

    if (do_load) begin
      state_n       = ARB_BUSY;
      grant_n       = win_oh;
      grant_valid_n = 1'b1;
      grant_idx_n   = win_idx;
      credit_left_n = win_credit;
      above_n       = win_thermo;
`ifdef WRR_ARBITER_LOCK_EN
      exhausted_n   = 1'b0;
`endif
    end
    if (do_clear) begin
      state_n       = ARB_IDLE;
      grant_n       = '0;
      grant_valid_n = 1'b0;
      grant_idx_n   = '0;
      credit_left_n = '0;
      above_n       = '0;
`ifdef WRR_ARBITER_LOCK_EN
      exhausted_n   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB_IDLE;
      mask        <= '0;
      above       <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      credit_left <= '0;
`ifdef WRR_ARBITER_LOCK_EN
      exhausted   <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      mask        <= mask_n;
      above       <= above_n;
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      grant_idx   <= grant_idx_n;
      credit_left <= credit_left_n;
`ifdef WRR_ARBITER_LOCK_EN
      exhausted   <= exhausted_n;
`endif
    end
  end

endmodule
